barrel_frame_ctrl: RTL

BARREL_FRAME_CTRL -- requirements
Module: barrel_frame_ctrl

---
 rtl/barrel_pkg.sv | 34 +++
 rtl/barrel_pix_counter.sv | 62 ++++++
 rtl/barrel_frame_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/barrel_pkg.sv
// barrel_pkg
// Shared definitions for the barrel-distortion frame controller: controller
// state encoding, bit positions inside the sticky error vector, reset values
// of the correction coefficients and a helper that sizes the counters.
package barrel_pkg;

  // Frame controller states. IDLE waits for enable, WAIT_SOF hunts for the
  // start-of-frame beat, RUN passes pixels through, PAD fills a short frame,
  // FLUSH discards the tail of a long frame, DRAIN waits for the core output.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SOF,
    ST_RUN,
    ST_PAD,
    ST_FLUSH,
    ST_DRAIN
  } state_t;

  // Positions of the sticky error flags inside err.
  localparam int ERR_SOF_MISSING = 0;
  localparam int ERR_EARLY_TLAST = 1;
  localparam int ERR_LATE_TLAST  = 2;
  localparam int ERR_TIMEOUT     = 3;

  // Coefficient values used after reset.
  localparam logic [15:0] K1_DEFAULT = 16'h0100;
  localparam logic [15:0] K2_DEFAULT = 16'h0020;

  // Number of bits needed to hold the values 0 .. maxCount-1 (at least one).
  function automatic int cntWidth(input int maxCount);
    return (maxCount > 1) ? $clog2(maxCount) : 1;
  endfunction

endpackage

// File: rtl/barrel_pix_counter.sv
// barrel_pix_counter
// Raster position counter for the input side of the frame controller.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   clear_i     return to pixel (0,0); takes priority over advance_i
//   advance_i   one pixel was accepted, step the raster position
//   first_o     current position is pixel 0 of the frame
//   last_o      current position is the final pixel of the frame
module barrel_pix_counter #(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 720
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic advance_i,
  output logic first_o,
  output logic last_o
);
  import barrel_pkg::*;

  localparam int XW = cntWidth(WIDTH);
  localparam int YW = cntWidth(HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // Next raster position: x wraps at the end of a line and carries into y,
  // y wraps at the end of the frame so a runaway source cannot overflow.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (advance_i) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign first_o = (x_q == '0) && (y_q == '0);
  assign last_o  = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/barrel_frame_ctrl.sv
// barrel_frame_ctrl
// Frame-level controller in front of a barrel-distortion correction core.
// It locks onto start-of-frame, forwards exactly WIDTH*HEIGHT pixels to the
// core (padding short frames, discarding the tail of long ones), hands the
// core a frame-stable pair of coefficients and waits for the core output to
// drain before starting the next frame.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   enable                    allow new frames to start
//   cfg_valid, cfg_k1/k2      load new coefficients into the shadow registers
//   err_clear                 clear the sticky error flags
//   s_axis_*                  source pixel stream (tuser = start of frame)
//   core_s_*                  pixel stream towards the correction core
//   core_m_tvalid/tready/tlast  observed handshake at the core output
//   core_k1, core_k2          coefficients in use for the current frame
//   busy                      a frame is in progress
//   frame_done                one-cycle pulse when a frame finishes
//   frame_count               number of finished frames (wraps)
//   err                       {timeout, late_tlast, early_tlast, sof_missing}
module barrel_frame_ctrl #(
  parameter int          WIDTH         = 1280,
  parameter int          HEIGHT        = 720,
  parameter int          DATA_WIDTH    = 24,
  parameter logic [15:0] K1_DEFAULT    = barrel_pkg::K1_DEFAULT,
  parameter logic [15:0] K2_DEFAULT    = barrel_pkg::K2_DEFAULT,
  parameter int          DRAIN_TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  cfg_valid,
  input  logic [15:0]           cfg_k1,
  input  logic [15:0]           cfg_k2,
  input  logic                  err_clear,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] core_s_tdata,
  output logic                  core_s_tvalid,
  output logic                  core_s_tlast,
  output logic                  core_s_tuser,
  input  logic                  core_s_tready,
  input  logic                  core_m_tvalid,
  input  logic                  core_m_tready,
  input  logic                  core_m_tlast,
  output logic [15:0]           core_k1,
  output logic [15:0]           core_k2,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic [3:0]            err
);
  import barrel_pkg::*;

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int OCW   = cntWidth(TOTAL + 1);
  localparam int TCW   = cntWidth(DRAIN_TIMEOUT);

  state_t          state_q, state_d;
  logic            pixFirst, pixLast, pixAdvance, pixClear;
  logic            pix0Accept, outHs, outDone, outCounting, drainExit;
  logic [3:0]      errSet;
  logic [3:0]      err_q;
  logic [OCW-1:0]  outCnt_q;
  logic [TCW-1:0]  drainTmr_q;
  logic [15:0]     shadowK1_q, shadowK2_q, coreK1_q, coreK2_q;
  logic [15:0]     frameCount_q;
  logic            frameDone_q;

  // The raster position restarts whenever we are between frames, so the
  // start-of-frame beat always lands on pixel 0.
  assign pixClear = (state_q == ST_IDLE) || (state_q == ST_WAIT_SOF);

  barrel_pix_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_in_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (pixClear),
    .advance_i(pixAdvance),
    .first_o  (pixFirst),
    .last_o   (pixLast)
  );

  assign pix0Accept = (state_q == ST_RUN) && pixFirst && s_axis_tvalid && core_s_tready;
  assign outHs      = core_m_tvalid && core_m_tready;

  // The frame is drained once every pixel came out of the core or the core
  // marks its last output beat; the handshake of this cycle already counts.
  assign outDone = (outCnt_q == OCW'(TOTAL)) ||
                   (outHs && (core_m_tlast || (outCnt_q == OCW'(TOTAL - 1))));

  // Output beats are only attributed to this frame from pixel 0 onwards.
  assign outCounting = busy && !((state_q == ST_RUN) && pixFirst && !pix0Accept);

  // Next-state and stream steering. In WAIT_SOF the start-of-frame beat is
  // held back (tready low for it) so RUN can forward it to the core as pixel 0.
  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b0;
    core_s_tvalid = 1'b0;
    core_s_tdata  = '0;
    core_s_tlast  = 1'b0;
    core_s_tuser  = 1'b0;
    pixAdvance    = 1'b0;
    errSet        = '0;
    drainExit     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        s_axis_tready = !(s_axis_tvalid && s_axis_tuser);
        if (s_axis_tvalid) begin
          if (s_axis_tuser) state_d = ST_RUN;
          else              errSet[ERR_SOF_MISSING] = 1'b1;
        end
      end
      ST_RUN: begin
        core_s_tvalid = s_axis_tvalid;
        s_axis_tready = core_s_tready;
        core_s_tdata  = s_axis_tdata;
        core_s_tuser  = pixFirst;
        core_s_tlast  = pixLast;
        if (s_axis_tvalid && core_s_tready) begin
          pixAdvance = 1'b1;
          if (pixLast) begin
            if (s_axis_tlast) begin
              state_d = ST_DRAIN;
            end else begin
              errSet[ERR_LATE_TLAST] = 1'b1;
              state_d = ST_FLUSH;
            end
          end else if (s_axis_tlast) begin
            errSet[ERR_EARLY_TLAST] = 1'b1;
            state_d = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        core_s_tvalid = 1'b1;
        core_s_tlast  = pixLast;
        if (core_s_tready) begin
          pixAdvance = 1'b1;
          if (pixLast) state_d = ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (outDone) begin
          drainExit = 1'b1;
        end else if (drainTmr_q == TCW'(DRAIN_TIMEOUT - 1)) begin
          drainExit = 1'b1;
          errSet[ERR_TIMEOUT] = 1'b1;
        end
        if (drainExit) state_d = enable ? ST_WAIT_SOF : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Output beat counter and DRAIN cycle timer. Both restart between frames;
  // the beat counter stops at a full frame so it cannot wrap.
  always_ff @(posedge clk) begin
    if (rst || pixClear) begin
      outCnt_q <= '0;
    end else if (outCounting && outHs && (outCnt_q != OCW'(TOTAL))) begin
      outCnt_q <= outCnt_q + OCW'(1);
    end
    if (rst || (state_q != ST_DRAIN)) drainTmr_q <= '0;
    else                              drainTmr_q <= drainTmr_q + TCW'(1);
  end

  // Coefficients: the shadow follows cfg_valid at any time, the core copy is
  // only refreshed when pixel 0 is accepted so a frame never sees a change.
  // A write in that same cycle goes straight to the core copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadowK1_q <= K1_DEFAULT;
      shadowK2_q <= K2_DEFAULT;
      coreK1_q   <= K1_DEFAULT;
      coreK2_q   <= K2_DEFAULT;
    end else begin
      if (cfg_valid) begin
        shadowK1_q <= cfg_k1;
        shadowK2_q <= cfg_k2;
      end
      if (pix0Accept) begin
        coreK1_q <= cfg_valid ? cfg_k1 : shadowK1_q;
        coreK2_q <= cfg_valid ? cfg_k2 : shadowK2_q;
      end
    end
  end

  // Sticky errors (a new error wins over a clear in the same cycle), the
  // frame-done pulse and the finished-frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q        <= '0;
      frameDone_q  <= 1'b0;
      frameCount_q <= '0;
    end else begin
      err_q       <= (err_clear ? 4'b0000 : err_q) | errSet;
      frameDone_q <= drainExit;
      if (drainExit) frameCount_q <= frameCount_q + 16'd1;
    end
  end

  assign busy        = (state_q == ST_RUN) || (state_q == ST_PAD) ||
                       (state_q == ST_FLUSH) || (state_q == ST_DRAIN);
  assign core_k1     = coreK1_q;
  assign core_k2     = coreK2_q;
  assign frame_done  = frameDone_q;
  assign frame_count = frameCount_q;
  assign err         = err_q;

endmodule
